// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Memory-side initiator for the 8-bit CPU's single-port byte memory.
//   Fetches a 16-bit instruction as two back-to-back byte reads (high byte
//   at the base address, low byte at base+1) and presents it to the decoder
//   with a valid/ready handshake. Optionally it also arbitrates a byte-wide
//   data load/store port onto the same memory, with data taking priority.
//
//   Build option: define FETCH_DATA_PORT_EN to include the d_* data port and
//   the data states. Without it, the unit is fetch-only and mem_rw_o and
//   mem_data_o are tied low.
//
//   Ports
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     fetch_req_i        PC requests an instruction at fetch_addr_i
//     fetch_addr_i       instruction address
//     fetch_busy_o       fetch in flight or instruction held
//     fetch_flush_i      abandon the current fetch
//     instr_o            {byte[addr], byte[addr+1]}
//     instr_valid_o      instr_o holds a complete word
//     instr_ready_i      decoder consumes instr_o
//     d_req_i, d_we_i    data request, 1 = store        (FETCH_DATA_PORT_EN)
//     d_addr_i, d_wdata_i data address and store data   (FETCH_DATA_PORT_EN)
//     d_rdata_o, d_ack_o load result, completion pulse  (FETCH_DATA_PORT_EN)
//     mem_rw_o, mem_addr_o, mem_data_o  registered memory request
//     mem_q_i            memory read data, valid one clock after the address
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | nothing in flight, arbitrate new requests
//   S_F_HI     | base address on the bus, present base+1 next
//   S_F_LO     | high byte returning, capture instr[15:8]
//   S_F_CAP    | low byte returning, capture instr[7:0], raise valid
//   S_HOLD     | instruction held for the decoder, arbitrate on consume
//   S_D_RD     | load address on the bus, waiting for the memory
//   S_D_RD_CAP | load data returning, capture and ack
//   S_D_WR     | store write cycle done, drop write enable and ack

module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_req_i,
  input  logic [ADDR_W-1:0]   fetch_addr_i,
  output logic                fetch_busy_o,
  input  logic                fetch_flush_i,
  output logic [2*DATA_W-1:0] instr_o,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
`ifdef FETCH_DATA_PORT_EN
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
`endif
  output logic                mem_rw_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_q_i
);

  // The capture states assume the byte returns exactly one clock after the
  // address is presented.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("instr_fetch_unit supports RD_LAT == 1 only");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_F_HI     = 3'd1,
    S_F_LO     = 3'd2,
    S_F_CAP    = 3'd3,
    S_HOLD     = 3'd4
`ifdef FETCH_DATA_PORT_EN
    ,
    S_D_RD     = 3'd5,
    S_D_RD_CAP = 3'd6,
    S_D_WR     = 3'd7
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [2*DATA_W-1:0]   instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fetch_busy_q, fetch_busy_d;
  logic                  arb;
  logic                  can_fetch;

`ifdef FETCH_DATA_PORT_EN
  logic                  mem_rw_q, mem_rw_d;
  logic [DATA_W-1:0]     mem_data_q, mem_data_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
  logic                  d_ack_q, d_ack_d;
`endif

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    base_d        = base_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_busy_d  = fetch_busy_q;
    arb           = 1'b0;
    can_fetch     = 1'b0;
`ifdef FETCH_DATA_PORT_EN
    // Write enable is a single-cycle strobe; only a store accept raises it.
    mem_rw_d      = 1'b0;
    mem_data_d    = mem_data_q;
    d_rdata_d     = d_rdata_q;
    d_ack_d       = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        arb       = 1'b1;
        // A fetch request coinciding with a flush is dropped; the PC re-asks.
        can_fetch = !fetch_flush_i;
      end
      S_F_HI: begin
        if (fetch_flush_i) begin
          state_d       = S_IDLE;
          instr_valid_d = 1'b0;
          fetch_busy_d  = 1'b0;
        end else begin
          mem_addr_d = base_q + ADDR_W'(1);
          state_d    = S_F_LO;
        end
      end
      S_F_LO: begin
        if (fetch_flush_i) begin
          state_d       = S_IDLE;
          instr_valid_d = 1'b0;
          fetch_busy_d  = 1'b0;
        end else begin
          instr_d[2*DATA_W-1:DATA_W] = mem_q_i;
          state_d                    = S_F_CAP;
        end
      end
      S_F_CAP: begin
        if (fetch_flush_i) begin
          state_d       = S_IDLE;
          instr_valid_d = 1'b0;
          fetch_busy_d  = 1'b0;
        end else begin
          instr_d[DATA_W-1:0] = mem_q_i;
          instr_valid_d       = 1'b1;
          state_d             = S_HOLD;
        end
      end
      S_HOLD: begin
        // Flush beats a simultaneous consume: the word is simply discarded.
        if (fetch_flush_i) begin
          state_d       = S_IDLE;
          instr_valid_d = 1'b0;
          fetch_busy_d  = 1'b0;
        end else begin
          arb = 1'b1;
          if (instr_valid_q && instr_ready_i) begin
            instr_valid_d = 1'b0;
            fetch_busy_d  = 1'b0;
            can_fetch     = 1'b1;
          end
        end
      end
`ifdef FETCH_DATA_PORT_EN
      S_D_RD: begin
        state_d = S_D_RD_CAP;
      end
      S_D_RD_CAP: begin
        d_rdata_d = mem_q_i;
        d_ack_d   = 1'b1;
        state_d   = instr_valid_q ? S_HOLD : S_IDLE;
      end
      S_D_WR: begin
        d_ack_d = 1'b1;
        state_d = instr_valid_q ? S_HOLD : S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared arbitration for IDLE and HOLD. A held, unconsumed instruction
    // stays put while a data access borrows the memory.
    if (arb) begin
      state_d = instr_valid_d ? S_HOLD : S_IDLE;
`ifdef FETCH_DATA_PORT_EN
      if (d_req_i) begin
        mem_addr_d = d_addr_i;
        if (d_we_i) begin
          mem_rw_d   = 1'b1;
          mem_data_d = d_wdata_i;
          state_d    = S_D_WR;
        end else begin
          state_d = S_D_RD;
        end
      end else
`endif
      if (can_fetch && fetch_req_i) begin
        mem_addr_d   = fetch_addr_i;
        base_d       = fetch_addr_i;
        fetch_busy_d = 1'b1;
        state_d      = S_F_HI;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      mem_addr_q    <= '0;
      base_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      base_q        <= base_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_busy_q  <= fetch_busy_d;
    end
  end

`ifdef FETCH_DATA_PORT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rw_q   <= 1'b0;
      mem_data_q <= '0;
      d_rdata_q  <= '0;
      d_ack_q    <= 1'b0;
    end else begin
      mem_rw_q   <= mem_rw_d;
      mem_data_q <= mem_data_d;
      d_rdata_q  <= d_rdata_d;
      d_ack_q    <= d_ack_d;
    end
  end

  assign mem_rw_o   = mem_rw_q;
  assign mem_data_o = mem_data_q;
  assign d_rdata_o  = d_rdata_q;
  assign d_ack_o    = d_ack_q;
`else
  assign mem_rw_o   = 1'b0;
  assign mem_data_o = '0;
`endif

  assign mem_addr_o    = mem_addr_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_busy_o  = fetch_busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic        fetch_busy;
  logic        fetch_flush = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
`ifdef FETCH_DATA_PORT_EN
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [7:0]  d_wdata = '0;
  logic [7:0]  d_rdata;
  logic        d_ack;
`endif
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q = '0;

  logic [7:0]  mem [0:65535];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rw_cycles = 0;

  instr_fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_req_i   (fetch_req),
    .fetch_addr_i  (fetch_addr),
    .fetch_busy_o  (fetch_busy),
    .fetch_flush_i (fetch_flush),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
`ifdef FETCH_DATA_PORT_EN
    .d_req_i       (d_req),
    .d_we_i        (d_we),
    .d_addr_i      (d_addr),
    .d_wdata_i     (d_wdata),
    .d_rdata_o     (d_rdata),
    .d_ack_o       (d_ack),
`endif
    .mem_rw_o      (mem_rw),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_q_i       (mem_q)
  );

  always #5 clk = ~clk;

  // Byte memory with one clock of read latency.
  always @(posedge clk) begin
    mem_q <= mem[mem_addr];
    if (mem_rw) mem[mem_addr] <= mem_data;
  end

  always @(negedge clk) if (mem_rw === 1'b1) rw_cycles++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts a fetch from IDLE; returns at the negedge after the 4th edge.
  task automatic run_fetch(input logic [15:0] a, input logic [15:0] exp, input logic rdy);
    logic [15:0] a1;
    a1 = a + 16'd1;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a; instr_ready = rdy;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("acc_addr", 32'(mem_addr), 32'(a));
    chk("acc_busy", 32'(fetch_busy), 1);
    chk("acc_rw", 32'(mem_rw), 0);
    chk("valid_e1", 32'(instr_valid), 0);
    @(negedge clk);
    chk("hi_addr", 32'(mem_addr), 32'(a1));
    chk("valid_e2", 32'(instr_valid), 0);
    @(negedge clk);
    chk("valid_e3", 32'(instr_valid), 0);
    chk("rw_e3", 32'(mem_rw), 0);
    @(negedge clk);
    chk("valid_e4", 32'(instr_valid), 1);
    chk("instr", 32'(instr), 32'(exp));
  endtask

  initial begin
    mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C;
    mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
    mem[16'h0020] = 8'hBE; mem[16'h0021] = 8'hEF;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rw", 32'(mem_rw), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(fetch_busy), 0);
`ifdef FETCH_DATA_PORT_EN
    chk("rst_rdata", 32'(d_rdata), 0);
    chk("rst_ack", 32'(d_ack), 0);
`endif
    rst_n = 1'b1;

    // Basic fetch, consumed immediately
    run_fetch(16'h0010, 16'hA53C, 1'b1);
    @(negedge clk);
    chk("consume_valid", 32'(instr_valid), 0);
    chk("consume_busy", 32'(fetch_busy), 0);

    // Address wrap
    run_fetch(16'hFFFF, 16'h1234, 1'b1);
    @(negedge clk);
    chk("wrap_consumed", 32'(instr_valid), 0);

    // Backpressure then flush, with a fetch request on the flush edge
    run_fetch(16'h0010, 16'hA53C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_instr", 32'(instr), 32'hA53C);
      chk("hold_valid", 32'(instr_valid), 1);
    end
    fetch_flush = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0020;
    @(negedge clk);
    fetch_flush = 1'b0; fetch_req = 1'b0;
    chk("flush_valid", 32'(instr_valid), 0);
    chk("flush_busy", 32'(fetch_busy), 0);
    chk("flush_noacc", 32'(mem_addr), 32'h0011);
    run_fetch(16'h0020, 16'hBEEF, 1'b0);

`ifdef FETCH_DATA_PORT_EN
    // Load served while an unconsumed instruction is held
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0011;
    @(negedge clk);
    d_req = 1'b0;
    chk("hld_ld_addr", 32'(mem_addr), 32'h0011);
    chk("hld_ld_ack1", 32'(d_ack), 0);
    @(negedge clk);
    chk("hld_ld_ack2", 32'(d_ack), 0);
    @(negedge clk);
    chk("hld_ld_ack3", 32'(d_ack), 1);
    chk("hld_ld_rdata", 32'(d_rdata), 32'h3C);
    chk("hld_ld_instr", 32'(instr), 32'hBEEF);
    chk("hld_ld_valid", 32'(instr_valid), 1);
`endif

    // Zero-bubble: consume and accept a new fetch on the same edge
    @(negedge clk);
    instr_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0010;
    @(negedge clk);
    fetch_req = 1'b0;
    chk("zb_valid", 32'(instr_valid), 0);
    chk("zb_busy", 32'(fetch_busy), 1);
    chk("zb_addr", 32'(mem_addr), 32'h0010);
    repeat (3) @(negedge clk);
    chk("zb_valid4", 32'(instr_valid), 1);
    chk("zb_instr", 32'(instr), 32'hA53C);
    @(negedge clk);
    chk("zb_consumed", 32'(instr_valid), 0);

`ifdef FETCH_DATA_PORT_EN
    // Store and fetch together: store wins, fetch follows
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 8'h77;
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    @(negedge clk);
    d_req = 1'b0;
    chk("st_rw", 32'(mem_rw), 1);
    chk("st_addr", 32'(mem_addr), 32'h0040);
    chk("st_data", 32'(mem_data), 32'h77);
    chk("st_nofetch", 32'(fetch_busy), 0);
    @(negedge clk);
    chk("st_rw_low", 32'(mem_rw), 0);
    chk("st_ack", 32'(d_ack), 1);
    @(negedge clk);
    fetch_req = 1'b0;
    chk("st_ack_pulse", 32'(d_ack), 0);
    chk("pf_busy", 32'(fetch_busy), 1);
    chk("pf_addr", 32'(mem_addr), 32'h0010);
    repeat (3) @(negedge clk);
    chk("pf_valid", 32'(instr_valid), 1);
    chk("pf_instr", 32'(instr), 32'hA53C);
    chk("st_mem", 32'(mem[16'h0040]), 32'h77);
    @(negedge clk);
    // Load back the stored byte
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    @(negedge clk);
    d_req = 1'b0;
    chk("ld_rw", 32'(mem_rw), 0);
    chk("ld_ack1", 32'(d_ack), 0);
    @(negedge clk);
    chk("ld_ack2", 32'(d_ack), 0);
    @(negedge clk);
    chk("ld_ack3", 32'(d_ack), 1);
    chk("ld_rdata", 32'(d_rdata), 32'h77);
    @(negedge clk);
    chk("ld_ack4", 32'(d_ack), 0);
`endif

    // Asynchronous reset while in F_LO
    @(negedge clk);
    instr_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 16'h0020;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(fetch_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(mem_addr), 0);
    chk("arst_instr", 32'(instr), 0);
    chk("arst_busy", 32'(fetch_busy), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_rw", 32'(mem_rw), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(instr_valid), 0);
      chk("post_rst_busy", 32'(fetch_busy), 0);
    end

`ifdef FETCH_DATA_PORT_EN
    chk("rw_cycles", 32'(rw_cycles), 1);
`else
    chk("rw_cycles", 32'(rw_cycles), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Memory-side initiator for the 8-bit CPU's single-port byte memory. It is the requesting end of the `mem` read/write port.
- Takes a 16-bit instruction address from the program counter and issues two back-to-back byte reads. It assembles a 16-bit instruction word and hands it to the decoder with a valid/ready handshake.
- Also arbitrates one byte-wide data load/store port onto the same memory.

Parameters:
- ADDR_W, 16, memory address width driven on mem_addr
- DATA_W, 8, memory byte width
- RD_LAT, 1, memory read latency in clocks, from the edge that presents the address to the edge where q is valid; fixed at 1 for this design

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  PC requests an instruction at fetch_addr
- fetch_addr  in  16  instruction address, even-aligned by convention
- fetch_busy  out  1  high while a fetch is in flight or held
- fetch_flush  in  1  abandon the current fetch (jump/branch taken)
- instr  out  16  assembled instruction; [15:8] = byte at fetch_addr, [7:0] = byte at fetch_addr+1
- instr_valid  out  1  instr holds a complete word
- instr_ready  in  1  decoder consumes instr
- d_req  in  1  data access request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  data byte address
- d_wdata  in  8  store data
- d_rdata  out  8  load result
- d_ack  out  1  one-cycle pulse: access complete; d_rdata valid on a load
- mem_rw  out  1  to memory: 1 = write, 0 = read
- mem_addr  out  16  to memory address
- mem_data  out  8  to memory write data
- mem_q  in  8  from memory read data (registered inside memory)

Behaviour:
- All memory-side outputs are registered.
- Reset (rst_n low, async) clears all outputs and the state:
  - mem_rw=0, mem_addr=0, mem_data=0
  - instr=0, instr_valid=0, fetch_busy=0
  - d_rdata=0, d_ack=0
  - state=IDLE
- Reset mid-fetch or mid-store drops the operation with no retry. A store is never issued after reset deassertion.
- States: IDLE, F_HI, F_LO, F_CAP, HOLD, D_RD, D_RD_CAP, D_WR.
- Arbitration is evaluated only in IDLE or HOLD. A data request (d_req) has priority over fetch_req.
- IDLE, fetch_req=1 and no d_req:
  - On the edge: mem_addr<=fetch_addr, mem_rw<=0, latch base address, fetch_busy<=1, go to F_HI.
- F_HI:
  - mem_addr<=base+1 (16-bit wrap, so 0xFFFF+1=0x0000), go to F_LO.
- F_LO:
  - instr[15:8]<=mem_q, go to F_CAP.
- F_CAP:
  - instr[7:0]<=mem_q, instr_valid<=1, go to HOLD.
  - instr_valid therefore rises 4 edges after the accept edge (accept edge plus the F_HI, F_LO and F_CAP edges).
- HOLD:
  - If instr_valid && instr_ready: instr_valid<=0 and fetch_busy<=0, then evaluate new requests on the same edge (zero-bubble back-to-back fetch).
  - A d_req in HOLD with instr_valid still high is served; instr is held unchanged and the FSM returns to HOLD afterwards.
- Data load:
  - Accept edge: mem_addr<=d_addr, mem_rw<=0, go to D_RD.
  - D_RD: go to D_RD_CAP.
  - D_RD_CAP: d_rdata<=mem_q, d_ack<=1 for one cycle.
- Data store:
  - Accept edge: mem_addr<=d_addr, mem_data<=d_wdata, mem_rw<=1, go to D_WR.
  - D_WR: mem_rw<=0, d_ack<=1.
  - mem_rw is high for exactly one clock per store.
- mem_rw is 0 in every state except the single store cycle, so no spurious writes occur.
- fetch_flush:
  - In F_HI/F_LO/F_CAP/HOLD: next state IDLE, instr_valid<=0, fetch_busy<=0. Returned bytes are discarded.
  - A fetch_req on the same edge as the flush is ignored; the PC re-requests next cycle.
  - Flush is ignored during data states; the data access completes normally.
- Simultaneous instr_ready and fetch_flush in HOLD: flush wins, and the instruction counts as not consumed.
- fetch_req while fetch_busy=1 is ignored. The PC must hold fetch_req until fetch_busy drops.

Optional Feature:
- FETCH_DATA_PORT_EN defined:
  - The d_* ports and the D_RD, D_RD_CAP and D_WR states exist as described above.
- FETCH_DATA_PORT_EN undefined:
  - d_* ports are omitted; the unit is fetch-only.
  - mem_rw and mem_data are tied to 0.
  - Arbitration logic is removed. All fetch timing is identical.

Test Plan:
- Reset then fetch: memory[0x0010]=0xA5, memory[0x0011]=0x3C; fetch_req with addr 0x0010, instr_ready=1 -> instr=0xA53C with instr_valid high exactly 4 edges after the accept edge; mem_rw stays 0 throughout.
- Wrap-around: memory[0xFFFF]=0x12, memory[0x0000]=0x34; fetch 0xFFFF -> mem_addr sequence 0xFFFF then 0x0000; instr=0x1234.
- Backpressure and flush: instr_ready=0 -> instr stable in HOLD for 5 cycles; assert fetch_flush -> instr_valid=0 next edge, state IDLE; a new fetch of 0x0020 returns the correct word.
- Data priority: d_req store (0x0040, 0x77) and fetch_req asserted together -> store first, mem_rw high for one cycle, d_ack pulse; the fetch follows; a later load of 0x0040 gives d_rdata=0x77 with d_ack 3 edges after accept.
- Async reset mid-fetch: rst_n low during F_LO -> all outputs 0 immediately; after release, no instr_valid until a new fetch_req.
- Build with FETCH_DATA_PORT_EN undefined: the fetch scenarios above pass unchanged, and mem_rw stays 0 for the whole test.
